mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one sequential multiplier (start/ready handshake, NBITS x NBITS -> 2*NBITS) between NREQ requesters.
- Selects a requester, drives the multiplier's operands and start, waits for completion, then returns the product to the winner with a one-cycle done pulse.
- A watchdog flags a multiplier that never returns ready.
- Sits between client blocks and the multn_NBITS8 instance.

Parameters:
- NBITS, 8, operand width; product width is 2*NBITS.
- NREQ, 2, number of requesters (2..8).
- TO_CYCLES, 300, watchdog limit in cycles spent in WAIT_DONE; must exceed 2^NBITS + 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- a_req  in  NREQ*NBITS  packed operand A; slice i belongs to requester i.
- b_req  in  NREQ*NBITS  packed operand B; slice i belongs to requester i.
- gnt  out  NREQ  one-hot; high from issue until done for the served requester.
- done  out  NREQ  one-hot, one-cycle pulse; result valid on res.
- err  out  1  one-cycle pulse alongside done when the watchdog expired.
- res  out  2*NBITS  registered product; holds until the next done.
- mul_start  out  1  multiplier start.
- mul_a  out  NBITS  multiplier operand A.
- mul_b  out  NBITS  multiplier operand B.
- mul_ready  in  1  multiplier idle/ready.
- mul_z  in  2*NBITS  multiplier product.

Behaviour:
- Reset (async, rst_b=0):
  - State=IDLE; rr pointer=0.
  - gnt, done, err, mul_start = 0; res, mul_a, mul_b = 0; watchdog count=0.
- Reset mid-operation aborts the transaction: no done is issued, and the requester must re-request.
- IDLE:
  - If any req bit is set and mul_ready=1, pick the first set bit at or after the rr pointer (wrapping).
  - Register the winner index, its a/b slices into mul_a/mul_b, and set gnt.
  - Next state is ISSUE.
  - If mul_ready=0, stay in IDLE.
- ISSUE (exactly 1 cycle): mul_start=1. Next state is WAIT_BUSY.
- WAIT_BUSY:
  - Stay while mul_ready=1, maximum 2 cycles.
  - Move to WAIT_DONE on mul_ready=0.
  - If mul_ready is still 1 after 2 cycles, go to WAIT_DONE anyway; this covers the multiplier's zero-operand fast path.
- WAIT_DONE:
  - Watchdog increments each cycle.
  - When mul_ready=1: res<=mul_z, then go to RESP.
  - When the watchdog reaches TO_CYCLES: res<=0, set the err flag, then go to RESP.
- RESP (1 cycle):
  - done[winner]=1; err=flag.
  - gnt cleared at the end of the cycle.
  - rr pointer <= winner+1 mod NREQ; flag and watchdog cleared.
  - Next state is IDLE.
- mul_a/mul_b hold stable from IDLE exit through RESP, because the multiplier samples operands in its load state.
- Latency: req seen in IDLE at cycle 0 -> mul_start at cycle 1 -> done at cycle (multiplier ready-return cycle + 2).
- Requester contract:
  - Hold req and operands until done.
  - Operand changes after the grant are ignored because operands are registered.
  - Dropping req after the grant does not abort; done is still pulsed.
  - req held high through done is a new request, arbitrated with the rotated pointer.
- Simultaneous requests: strict round-robin, so no requester waits more than NREQ-1 transactions.
- The block never asserts mul_start unless mul_ready=1 in the issue cycle.

Decomposition:
- Package mult_share_pkg: state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP), the watchdog counter width function clog2(TO_CYCLES+1), and the WAIT_BUSY limit constant (2).
- One sub-module, rr_pick: combinational round-robin priority select (req, ptr -> one-hot grant and index).
- The FSM, datapath registers and watchdog live in the top level.

Test Plan:
- Single request, req=01, a_req[0]=7, b_req[0]=9, real multn_NBITS8 -> mul_start 1 cycle; done=01 once; res=63; err=0; gnt=01 only during the transaction.
- Contention: req=11 held, requester0 (12x10) and requester1 (5x5), ptr=0 -> done order 01 (res=120), then 10 (res=25), then 01 again; no starvation.
- Zero operand: a=0, b=200 -> done with res=0, err=0; the multiplier zero fast path completes without hang.
- Max operands: 255x255 -> res=65025, err=0, within TO_CYCLES.
- Watchdog: stub multiplier that holds mul_ready=0 after start -> done and err pulse together after TO_CYCLES cycles in WAIT_DONE; res=0; next request is served normally.
- Reset mid-op: rst_b low during WAIT_DONE -> all outputs 0 immediately; no done; after release, a req=10 is served first because the pointer reset to 0 and bit 1 is the only request.

Source files
------------

// File: rtl/mult_share_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
// Latency: n/a (types and compile-time helpers only).
// Backpressure: n/a.
package mult_share_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // Cycles to wait for the multiplier to drop ready after start.
  // The zero-operand fast path never drops ready, so the wait must be bounded.
  localparam int BUSY_LIMIT = 2;

  // Width of a counter that can hold the value to_cycles.
  function automatic int wd_width(input int to_cycles);
    return $clog2(to_cycles + 1);
  endfunction

  // Width of a requester index, at least 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_share_arb_rr_pick.sv
// Round-robin priority select: first set request at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic            o_vld,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDXW-1:0] o_idx
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [IDXW:0]     w_sum;

  // Rotate the requests so bit 0 of w_rot is the requester under the pointer.
  assign w_dbl = {i_req, i_req};
  assign w_rot = NREQ'(w_dbl >> i_ptr);

  // Lowest set bit of the rotated vector wins; map it back to an absolute index.
  always_comb begin
    o_vld = 1'b0;
    w_sum = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_vld = 1'b1;
        w_sum = {1'b0, i_ptr} + (IDXW + 1)'(i);
      end
    end
    if (w_sum >= (IDXW + 1)'(NREQ)) begin
      o_idx = IDXW'(w_sum - (IDXW + 1)'(NREQ));
    end else begin
      o_idx = w_sum[IDXW-1:0];
    end
  end

  assign o_gnt = o_vld ? (NREQ'(1) << o_idx) : '0;

endmodule

// File: rtl/mult_share_arb.sv
// Shares one start/ready sequential multiplier between NREQ requesters, round-robin.
// Latency: req seen in IDLE -> mul_start next cycle -> done one cycle after the product is captured.
// Backpressure: waits in IDLE while the multiplier is not ready; watchdog ends a hung multiply.
module mult_share_arb
  import mult_share_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter int NREQ      = 2,
  parameter int TO_CYCLES = 300
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] a_req,
  input  logic [NREQ*NBITS-1:0] b_req,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic [2*NBITS-1:0]    res,
  output logic                  mul_start,
  output logic [NBITS-1:0]      mul_a,
  output logic [NBITS-1:0]      mul_b,
  input  logic                  mul_ready,
  input  logic [2*NBITS-1:0]    mul_z
);

  localparam int IDXW = idx_width(NREQ);
  localparam int WDW  = wd_width(TO_CYCLES);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDXW-1:0]    r_ptr;
  logic [IDXW-1:0]    r_idx;
  logic [NREQ-1:0]    r_gnt;
  logic [NBITS-1:0]   r_mul_a;
  logic [NBITS-1:0]   r_mul_b;
  logic [2*NBITS-1:0] r_res;
  logic               r_err_flag;
  logic [WDW-1:0]     r_wd;
  logic [1:0]         r_busy_cnt;

  logic               w_pick_vld;
  logic [NREQ-1:0]    w_pick_gnt;
  logic [IDXW-1:0]    w_pick_idx;
  logic [NBITS-1:0]   w_a;
  logic [NBITS-1:0]   w_b;
  logic               w_launch;
  logic               w_busy_exit;
  logic               w_wd_exp;

  rr_pick #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_vld (w_pick_vld),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx)
  );

  // Operand slices of the current pick.
  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_gnt[i]) begin
        w_a = a_req[i*NBITS +: NBITS];
        w_b = b_req[i*NBITS +: NBITS];
      end
    end
  end

  assign w_launch    = (r_state == IDLE) && w_pick_vld && mul_ready;
  assign w_busy_exit = !mul_ready || (r_busy_cnt == 2'(BUSY_LIMIT - 1));
  assign w_wd_exp    = (r_wd == WDW'(TO_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_launch) w_state_nxt = ISSUE;
      ISSUE:     w_state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (w_busy_exit) w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (mul_ready || w_wd_exp) w_state_nxt = RESP;
      RESP:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs; start is gated by ready so a busy multiplier is never kicked.
  always_comb begin
    mul_start = (r_state == ISSUE) && mul_ready;
    done      = (r_state == RESP) ? r_gnt : '0;
    err       = (r_state == RESP) && r_err_flag;
  end

  // Datapath: winner capture, operand hold, result capture, watchdog and pointer rotation.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr      <= '0;
      r_idx      <= '0;
      r_gnt      <= '0;
      r_mul_a    <= '0;
      r_mul_b    <= '0;
      r_res      <= '0;
      r_err_flag <= 1'b0;
      r_wd       <= '0;
      r_busy_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_launch) begin
            r_idx   <= w_pick_idx;
            r_gnt   <= w_pick_gnt;
            r_mul_a <= w_a;
            r_mul_b <= w_b;
          end
        end
        ISSUE: begin
          r_busy_cnt <= '0;
        end
        WAIT_BUSY: begin
          r_busy_cnt <= r_busy_cnt + 2'd1;
        end
        WAIT_DONE: begin
          r_wd <= r_wd + WDW'(1);
          if (mul_ready) begin
            r_res <= mul_z;
          end else if (w_wd_exp) begin
            r_res      <= '0;
            r_err_flag <= 1'b1;
          end
        end
        RESP: begin
          r_gnt      <= '0;
          r_ptr      <= (r_idx == IDXW'(NREQ - 1)) ? '0 : r_idx + IDXW'(1);
          r_err_flag <= 1'b0;
          r_wd       <= '0;
          r_busy_cnt <= '0;
        end
        default: begin
          r_gnt <= '0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign res   = r_res;
  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb with a behavioural start/ready multiplier (stallable).
// Latency: model multiplier busy M_LAT cycles; zero operands return at once without dropping ready.
// Backpressure: model can be held busy forever to exercise the watchdog.
module tb_mult_share_arb;

  localparam int NBITS     = 8;
  localparam int NREQ      = 2;
  localparam int TO_CYCLES = 300;
  localparam int M_LAT     = 10;

  logic                  clk;
  logic                  rst_b;
  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] a_req;
  logic [NREQ*NBITS-1:0] b_req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [2*NBITS-1:0]    res;
  logic                  mul_start;
  logic [NBITS-1:0]      mul_a;
  logic [NBITS-1:0]      mul_b;
  logic                  mul_ready;
  logic [2*NBITS-1:0]    mul_z;

  logic m_stuck;
  int   m_cnt;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    logic [NREQ-1:0]    req;
    logic [NBITS-1:0]   a0;
    logic [NBITS-1:0]   b0;
    logic [NBITS-1:0]   a1;
    logic [NBITS-1:0]   b1;
    logic [NREQ-1:0]    done;
    logic [2*NBITS-1:0] res;
    logic               err;
  } vec_t;

  vec_t vecs [7];

  mult_share_arb #(
    .NBITS     (NBITS),
    .NREQ      (NREQ),
    .TO_CYCLES (TO_CYCLES)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       (req),
    .a_req     (a_req),
    .b_req     (b_req),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .res       (res),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_ready (mul_ready),
    .mul_z     (mul_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: product is formed from mul_a/mul_b at completion, so operands must stay put.
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      mul_ready <= 1'b1;
      m_cnt     <= 0;
      mul_z     <= '0;
    end else if (mul_start && mul_ready) begin
      if (mul_a == '0 || mul_b == '0) begin
        mul_z <= '0;
      end else begin
        mul_ready <= 1'b0;
        m_cnt     <= M_LAT;
      end
    end else if (!mul_ready && !m_stuck) begin
      if (m_cnt <= 1) begin
        mul_ready <= 1'b1;
        mul_z     <= (2*NBITS)'(mul_a) * (2*NBITS)'(mul_b);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A start must only be issued to an idle multiplier.
  always @(negedge clk) begin
    if (rst_b && mul_start) chk("start_needs_ready", 32'(mul_ready), 32'd1);
  end

  function automatic vec_t mk(input int rq, input int a0, input int b0, input int a1,
                              input int b1, input int dn, input int rs, input int er);
    vec_t v;
    v.req  = NREQ'(rq);
    v.a0   = NBITS'(a0);
    v.b0   = NBITS'(b0);
    v.a1   = NBITS'(a1);
    v.b1   = NBITS'(b1);
    v.done = NREQ'(dn);
    v.res  = (2*NBITS)'(rs);
    v.err  = 1'(er);
    return v;
  endfunction

  // Waits for a done pulse (always advancing at least one cycle); reports starts seen and start->done cycles.
  task automatic wait_done(input string tag, input int budget, output int n_st, output int lat);
    int k;
    int ks;
    k    = 0;
    ks   = -1;
    n_st = 0;
    do begin
      @(negedge clk);
      k++;
      if (mul_start) begin
        n_st++;
        if (ks < 0) ks = k;
      end
    end while (done == '0 && k < budget);
    chk({tag, "_done_seen"}, 32'(done != '0), 32'd1);
    lat = (ks < 0) ? -1 : k - ks;
  endtask

  initial begin
    int ns;
    int lat;
    n_cmp   = 0;
    n_bad   = 0;
    rst_b   = 1'b0;
    req     = '0;
    a_req   = '0;
    b_req   = '0;
    m_stuck = 1'b0;

    //            req  a0  b0   a1   b1  done  res    err
    vecs[0] = mk(2'b01,  7,   9,   0,   0, 2'b01,    63, 0);
    vecs[1] = mk(2'b10,  0,   0,   3,   4, 2'b10,    12, 0);
    vecs[2] = mk(2'b11, 12,  10,   5,   5, 2'b01,   120, 0);
    vecs[3] = mk(2'b11, 12,  10,   5,   5, 2'b10,    25, 0);
    vecs[4] = mk(2'b11, 12,  10,   5,   5, 2'b01,   120, 0);
    vecs[5] = mk(2'b01,  0, 200,   0,   0, 2'b01,     0, 0);
    vecs[6] = mk(2'b10,  0,   0, 255, 255, 2'b10, 65025, 0);

    repeat (3) @(negedge clk);
    chk("rst_gnt",   32'(gnt),       32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_err",   32'(err),       32'd0);
    chk("rst_start", 32'(mul_start), 32'd0);
    chk("rst_res",   32'(res),       32'd0);
    chk("rst_mul_a", 32'(mul_a),     32'd0);
    chk("rst_mul_b", 32'(mul_b),     32'd0);
    rst_b = 1'b1;

    // Table: single requests, round-robin contention with req held, zero and max operands.
    for (int i = 0; i < 7; i++) begin
      string t;
      t     = $sformatf("v%0d", i);
      req   = vecs[i].req;
      a_req = {vecs[i].a1, vecs[i].a0};
      b_req = {vecs[i].b1, vecs[i].b0};
      wait_done(t, 200, ns, lat);
      chk({t, "_done"},   32'(done), 32'(vecs[i].done));
      chk({t, "_gnt"},    32'(gnt),  32'(vecs[i].done));
      chk({t, "_res"},    32'(res),  32'(vecs[i].res));
      chk({t, "_err"},    32'(err),  32'(vecs[i].err));
      chk({t, "_starts"}, 32'(ns),   32'd1);
    end
    req = '0;
    @(negedge clk);
    chk("idle_gnt_clear",  32'(gnt),  32'd0);
    chk("idle_done_clear", 32'(done), 32'd0);

    // Operands changed and req dropped after the grant: original operands used, done still pulsed.
    req   = 2'b01;
    a_req = {8'd0, 8'd4};
    b_req = {8'd0, 8'd5};
    @(negedge clk);
    chk("chg_gnt_next_cycle", 32'(gnt),       32'd1);
    chk("chg_start",          32'(mul_start), 32'd1);
    req   = 2'b00;
    a_req = {8'd0, 8'd9};
    b_req = {8'd0, 8'd9};
    wait_done("chg", 200, ns, lat);
    chk("chg_done", 32'(done), 32'd1);
    chk("chg_res",  32'(res),  32'd20);

    // Watchdog: multiplier never returns ready.
    m_stuck = 1'b1;
    req     = 2'b10;
    a_req   = {8'd2, 8'd0};
    b_req   = {8'd3, 8'd0};
    wait_done("wd", TO_CYCLES + 50, ns, lat);
    chk("wd_done", 32'(done), 32'd2);
    chk("wd_err",  32'(err),  32'd1);
    chk("wd_res",  32'(res),  32'd0);
    chk("wd_lat_window", 32'(lat >= TO_CYCLES && lat <= TO_CYCLES + 3), 32'd1);
    req = '0;
    @(negedge clk);
    chk("wd_err_pulse", 32'(err),  32'd0);
    chk("wd_done_pulse", 32'(done), 32'd0);
    chk("wd_gnt_clear", 32'(gnt),  32'd0);
    m_stuck = 1'b0;

    // Recovery: next request served normally once the multiplier is ready again.
    req   = 2'b01;
    a_req = {8'd0, 8'd11};
    b_req = {8'd0, 8'd11};
    wait_done("rec", 200, ns, lat);
    chk("rec_done", 32'(done), 32'd1);
    chk("rec_res",  32'(res),  32'd121);
    chk("rec_err",  32'(err),  32'd0);

    // Reset while waiting for the product: everything clears, transaction is lost.
    req   = 2'b01;
    a_req = {8'd0, 8'd3};
    b_req = {8'd0, 8'd3};
    repeat (5) @(negedge clk);
    chk("mid_gnt_before", 32'(gnt), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_gnt",   32'(gnt),       32'd0);
    chk("mid_done",  32'(done),      32'd0);
    chk("mid_err",   32'(err),       32'd0);
    chk("mid_start", 32'(mul_start), 32'd0);
    chk("mid_res",   32'(res),       32'd0);
    chk("mid_mul_a", 32'(mul_a),     32'd0);
    chk("mid_mul_b", 32'(mul_b),     32'd0);
    req = '0;
    repeat (2) @(negedge clk);
    req   = 2'b10;
    a_req = {8'd6, 8'd0};
    b_req = {8'd7, 8'd0};
    rst_b = 1'b1;
    wait_done("post", 200, ns, lat);
    chk("post_done", 32'(done), 32'd2);
    chk("post_res",  32'(res),  32'd42);
    chk("post_err",  32'(err),  32'd0);
    req = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
